// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: drain FSM states and the machine word.
package pipeline_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of sequencer signals; pc modport faces the controller, tb modport drives it.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
) (
    input logic CLK
);
    logic             RST;
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             flush;
    logic             insert_nop;
    logic             id_halt;
    logic             wb_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             imemREN;
    logic             halt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport pc (
        input  CLK, RST, ihit, dhit, mem_dREN, mem_dWEN, flush, insert_nop, id_halt, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               imemREN, halt, cycle_cnt, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               imemREN, halt, cycle_cnt, stall_cnt, flush_cnt,
        output RST, ihit, dhit, mem_dREN, mem_dWEN, flush, insert_nop, id_halt, wb_halt
    );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Event counter: counts cycles with inc high, wraps modulo 2^CNT_W.
// Latency: count reflects inc one cycle later. No backpressure.
// Backpressure: none; freezing is done by the caller holding inc low.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: PC/latch enables and flushes, halt drain FSM, perf counters.
// Latency: enables/flushes are combinational (zero cycle); state, halt and counters registered.
// Backpressure: a pending data access holds PC..EX/MEM and bubbles MEM/WB until dhit.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             flush,
    input  logic             insert_nop,
    input  logic             id_halt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             imemREN,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t state;
    pipe_state_t state_nxt;
    logic        dstall;
    logic        cycle_inc;
    logic        stall_inc;
    logic        flush_inc;

    assign dstall = (mem_dREN | mem_dWEN) & ~dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= state_nxt;
            halt  <= (state_nxt == HALTED);
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        imemREN     = 1'b0;
        cycle_inc   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            RUN, DRAIN: begin
                cycle_inc = 1'b1;
                imemREN   = (state == RUN);
                // A stalled data access outranks redirects: EX is held so requests re-present.
                if (dstall) begin
                    memwb_flush = 1'b1;
                    stall_inc   = 1'b1;
                end else if (flush) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    flush_inc  = 1'b1;
                    state_nxt  = RUN;
                end else if (insert_nop) begin
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    stall_inc  = 1'b1;
                end else if (state == RUN && id_halt) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    state_nxt  = DRAIN;
                end else if (state == RUN && !ihit) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    stall_inc  = 1'b1;
                end else if (state == RUN) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end

                // Halt reaching WB has committed, so it outranks a younger redirect.
                if (state == DRAIN && !dstall && wb_halt) begin
                    state_nxt = HALTED;
                end
            end
            default: begin
            end
        endcase
    end

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (cycle_inc),
        .count (cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: RUN-state decode table plus multi-cycle sequences.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // Input pattern bit order: {mem_dREN, mem_dWEN, dhit, ihit, flush, insert_nop, id_halt, wb_halt}
    localparam logic [7:0] IDLE = 8'b0001_0000;
    // Output bit order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //                    ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN}
    localparam logic [9:0] O_RUN   = 10'b11111_0000_1;
    localparam logic [9:0] O_MISS  = 10'b00111_1000_1;
    localparam logic [9:0] O_DST   = 10'b00000_0001_1;
    localparam logic [9:0] O_FLUSH = 10'b10011_1100_1;
    localparam logic [9:0] O_NOP   = 10'b00011_0100_1;
    localparam logic [9:0] O_DRAIN = 10'b00111_1000_0;
    localparam logic [9:0] O_DRFL  = 10'b10011_1100_0;

    typedef struct {
        string      name;
        logic [7:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk;
    int   n_vec;
    int   n_err;
    vec_t vecs[13];

    pipeline_ctrl_if #(.CNT_W(CNT_W)) pif (.CLK(clk));

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK         (clk),
        .RST         (pif.RST),
        .ihit        (pif.ihit),
        .dhit        (pif.dhit),
        .mem_dREN    (pif.mem_dREN),
        .mem_dWEN    (pif.mem_dWEN),
        .flush       (pif.flush),
        .insert_nop  (pif.insert_nop),
        .id_halt     (pif.id_halt),
        .wb_halt     (pif.wb_halt),
        .pc_en       (pif.pc_en),
        .ifid_en     (pif.ifid_en),
        .idex_en     (pif.idex_en),
        .exmem_en    (pif.exmem_en),
        .memwb_en    (pif.memwb_en),
        .ifid_flush  (pif.ifid_flush),
        .idex_flush  (pif.idex_flush),
        .exmem_flush (pif.exmem_flush),
        .memwb_flush (pif.memwb_flush),
        .imemREN     (pif.imemREN),
        .halt        (pif.halt),
        .cycle_cnt   (pif.cycle_cnt),
        .stall_cnt   (pif.stall_cnt),
        .flush_cnt   (pif.flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush, pif.imemREN};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        {pif.mem_dREN, pif.mem_dWEN, pif.dhit, pif.ihit,
         pif.flush, pif.insert_nop, pif.id_halt, pif.wb_halt} = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pif.RST = 1'b1;
        drive(IDLE);
        @(negedge clk);
        pif.RST = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pif.RST = 1'b0;
        drive(IDLE);

        vecs[0]  = '{"idle",             8'b0001_0000, O_RUN};
        vecs[1]  = '{"imiss",            8'b0000_0000, O_MISS};
        vecs[2]  = '{"dread_stall",      8'b1001_0000, O_DST};
        vecs[3]  = '{"dwrite_stall_fl",  8'b0101_1100, O_DST};
        vecs[4]  = '{"dread_hit",        8'b1011_0000, O_RUN};
        vecs[5]  = '{"flush",            8'b0001_1000, O_FLUSH};
        vecs[6]  = '{"flush_nop_halt",   8'b0001_1110, O_FLUSH};
        vecs[7]  = '{"nop",              8'b0001_0100, O_NOP};
        vecs[8]  = '{"nop_imiss",        8'b0000_0100, O_NOP};
        vecs[9]  = '{"id_halt",          8'b0001_0010, O_MISS};
        vecs[10] = '{"wb_halt_in_run",   8'b0001_0001, O_RUN};
        vecs[11] = '{"dstall_id_halt",   8'b1001_0010, O_DST};
        vecs[12] = '{"dwrite_hit_flush", 8'b0111_1000, O_FLUSH};

        // Reset state while RST held, then cycle count over 10 idle cycles
        @(negedge clk);
        pif.RST = 1'b1;
        #1;
        check("rst_outs", 32'(outs()), 32'(O_RUN));
        check("rst_halt", 32'(pif.halt), 32'd0);
        check("rst_cycle", pif.cycle_cnt, 32'd0);
        check("rst_flush", pif.flush_cnt, 32'd0);
        @(negedge clk);
        pif.RST = 1'b0;
        repeat (10) @(negedge clk);
        check("cycle_10", pif.cycle_cnt, 32'd10);
        check("stall_10", pif.stall_cnt, 32'd0);

        // Combinational decode in RUN; inputs return to idle before each edge
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            drive(IDLE);
            @(negedge clk);
        end
        check("table_stall_cnt", pif.stall_cnt, 32'd0);

        // Data stall holds off a pending flush for 3 cycles, then flush is honoured
        do_reset();
        drive(8'b1001_1000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dstall_pc_en", 32'(pif.pc_en), 32'd0);
            check("dstall_memwb_flush", 32'(pif.memwb_flush), 32'd1);
            @(negedge clk);
        end
        check("dstall_flush_cnt", pif.flush_cnt, 32'd0);
        check("dstall_stall_cnt", pif.stall_cnt, 32'd3);
        drive(8'b1011_1000);
        #1;
        check("dhit_flush_outs", 32'(outs()), 32'(O_FLUSH));
        @(negedge clk);
        drive(IDLE);
        check("dhit_flush_cnt", pif.flush_cnt, 32'd1);
        check("dhit_stall_cnt", pif.stall_cnt, 32'd3);
        check("dhit_cycle_cnt", pif.cycle_cnt, 32'd4);

        // Single insert_nop cycle counts one stall
        do_reset();
        drive(8'b0001_0100);
        @(negedge clk);
        drive(IDLE);
        check("nop_stall_cnt", pif.stall_cnt, 32'd1);

        // Wrong-path halt: DRAIN, then flush returns to RUN
        do_reset();
        drive(8'b0001_0010);
        @(negedge clk);
        drive(IDLE);
        #1;
        check("drain_outs", 32'(outs()), 32'(O_DRAIN));
        @(negedge clk);
        drive(8'b0001_1000);
        #1;
        check("drain_flush_outs", 32'(outs()), 32'(O_DRFL));
        @(negedge clk);
        drive(IDLE);
        #1;
        check("redirect_outs", 32'(outs()), 32'(O_RUN));
        check("redirect_halt", 32'(pif.halt), 32'd0);
        check("redirect_flush_cnt", pif.flush_cnt, 32'd1);

        // dstall with wb_halt in DRAIN stays in DRAIN
        do_reset();
        drive(8'b0001_0010);
        @(negedge clk);
        drive(8'b1001_0001);
        @(negedge clk);
        drive(IDLE);
        #1;
        check("dstall_wbhalt_halt", 32'(pif.halt), 32'd0);
        check("dstall_wbhalt_outs", 32'(outs()), 32'(O_DRAIN));

        // Full halt: id_halt, drain two cycles, wb_halt, then frozen
        do_reset();
        drive(8'b0001_0010);
        @(negedge clk);
        drive(IDLE);
        @(negedge clk);
        @(negedge clk);
        drive(8'b0001_0001);
        #1;
        check("pre_halt", 32'(pif.halt), 32'd0);
        check("pre_halt_imem", 32'(pif.imemREN), 32'd0);
        @(negedge clk);
        drive(IDLE);
        #1;
        check("halted_halt", 32'(pif.halt), 32'd1);
        check("halted_outs", 32'(outs()), 32'd0);
        check("halted_cycle", pif.cycle_cnt, 32'd4);
        drive(8'b1001_1110);
        repeat (5) @(negedge clk);
        #1;
        check("frozen_halt", 32'(pif.halt), 32'd1);
        check("frozen_outs", 32'(outs()), 32'd0);
        check("frozen_cycle", pif.cycle_cnt, 32'd4);
        check("frozen_stall", pif.stall_cnt, 32'd0);
        check("frozen_flush", pif.flush_cnt, 32'd0);

        // Asynchronous reset mid-cycle while HALTED
        drive(IDLE);
        pif.RST = 1'b1;
        #1;
        check("arst_halt", 32'(pif.halt), 32'd0);
        check("arst_outs", 32'(outs()), 32'(O_RUN));
        check("arst_cycle", pif.cycle_cnt, 32'd0);
        @(negedge clk);
        pif.RST = 1'b0;
        @(negedge clk);
        check("post_arst_cycle", pif.cycle_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline. Each cycle it combines cache handshakes (ihit, dhit), hazard-unit decisions (flush, insert_nop) and halt progress into the PC enable, the four pipeline-latch enable/flush pairs, and the instruction-memory read request. It also owns the halt drain sequence and three performance counters. It sits beside the hazard unit in the datapath top and is the only driver of latch enables.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN, mem_dWEN  in  1 each  the MEM-stage instruction is performing a data read or write.
- flush  in  1  branch misprediction from the hazard unit; redirect the PC.
- insert_nop  in  1  load-use bubble request from the hazard unit.
- id_halt  in  1  the ID stage holds a halt instruction.
- wb_halt  in  1  the WB stage holds a halt instruction.
- pc_en  out  1  PC register load.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clear (bubble). Clear has priority over enable inside the latch.
- imemREN  out  1  instruction read request.
- halt  out  1  CPU halted; sticky.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Signal definition: dstall = (mem_dREN | mem_dWEN) & ~dhit.
- Priority, applied in RUN and DRAIN, first match wins:
  1. dstall: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush=1. flush and insert_nop are ignored, because the EX stage is held and the request persists.
  2. flush: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1. In DRAIN, go to RUN (the halt was wrong-path). flush_cnt increments.
  3. insert_nop: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
  4. RUN with id_halt: pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1. Go to DRAIN.
  5. RUN with ~ihit: pc_en=0, ifid_flush=1, all other latches enabled.
  6. RUN otherwise: all enables 1, pc_en=1.
  7. DRAIN otherwise: pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1.
- In DRAIN, wb_halt with no dstall moves the FSM to HALTED.
- imemREN is 1 only in RUN.
- HALTED: all enables, flushes, pc_en and imemREN are 0. halt=1 until reset.
- Any output not named in a case is 0.
- Counters:
  - cycle_cnt increments every cycle the FSM is not in HALTED.
  - stall_cnt increments on cycles matching rule 1, 3 or 5.
  - flush_cnt increments on rule 2.
  - All counters wrap modulo 2^CNT_W and freeze in HALTED.

## Timing
- State, halt and all counters are registered. Every other output is combinational from state and inputs, with zero latency.
- Reset (async): state=RUN, halt=0, all counters=0. Immediately after reset the combinational outputs follow RUN rules, so imemREN=1.
- RST asserted mid-drain or while HALTED returns to RUN within the same cycle, asynchronously.
- halt rises the cycle after wb_halt is sampled in DRAIN.
- dstall coinciding with wb_halt: stay in DRAIN. The halt is still in MEM behind the stalled access.
- flush together with id_halt in RUN: rule 2 wins and there is no DRAIN entry.

## Structure
- Add pipe_state_t (RUN, DRAIN, HALTED) to datapath_types_pkg. Use word_t from cpu_types_pkg when CNT_W=32.
- Add a pipeline_ctrl_if interface with pc and tb modports, alongside the hazard unit interface.
- One sub-module: perf_counter, with parameter CNT_W, inputs CLK, RST and inc, output count. It is instantiated three times.

## Test plan
- Reset with ihit=1, no hazards → all enables 1, imemREN=1, counters 0. After 10 cycles, cycle_cnt=10 and stall_cnt=0.
- mem_dREN=1, dhit=0 for 3 cycles with flush=1 held → pc_en=0, memwb_flush=1 each cycle, flush_cnt unchanged, stall_cnt=3. Then dhit=1 → flush honoured, flush_cnt=1.
- insert_nop=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
- id_halt=1, then flush=1 two cycles later → DRAIN then RUN, imemREN back to 1, halt stays 0.
- id_halt=1, then wb_halt=1 three cycles later → halt=1 on the next edge. cycle_cnt frozen, all outputs 0.
- RST pulse while HALTED → halt=0, state RUN, counters 0, imemREN=1 immediately.
